// File: rtl/fpu_round_pipe.sv
// Two-stage IEEE-754 rounding and packing unit: stage 1 resolves the rounding
// mode and increment decision, stage 2 applies it, saturates on overflow and packs.
module fpu_round_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic                     sign_i,
   input  logic [EXP_W+1:0]         exp_i,
   input  logic [MAN_W:0]           man_i,
   input  logic [1:0]               rs_i,
   input  logic [2:0]               rm_i,
   input  logic [2:0]               frm_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [EXP_W+MAN_W:0]     result_o,
   output logic [2:0]               fflags_o,
   output logic                     illegal_rm_o
);

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   localparam logic [EXP_W+1:0] EXP_OVF  = {2'b00, {EXP_W{1'b1}}};
   localparam logic [EXP_W+1:0] EXP_ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
   localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

   logic advance;

   // stage 1 registers
   logic             s1_valid;
   logic             s1_sign;
   logic [EXP_W+1:0] s1_exp;
   logic [MAN_W:0]   s1_man;
   logic             s1_inc;
   logic [2:0]       s1_erm;
   logic             s1_nx;
   logic             s1_illegal;

   logic s2_valid;

   // stage 1 combinational decision
   logic [2:0] erm;
   logic       illegal;
   logic       inc;
   logic       bit_l;
   logic       bit_r;
   logic       bit_s;

   // stage 2 combinational round/pack
   logic [MAN_W+1:0]   sum;
   logic [EXP_W+1:0]   exp_f;
   logic [MAN_W-1:0]   frac_f;
   logic               of;
   logic               of_to_inf;
   logic               nx;
   logic               uf;
   logic [EXP_W+MAN_W:0] res_n;
   logic [2:0]         flags_n;

   assign advance     = ~s2_valid | out_ready_i;
   assign in_ready_o  = advance;
   assign out_valid_o = s2_valid;

   always_comb begin
      erm     = (rm_i == RM_DYN) ? frm_i : rm_i;
      illegal = erm[2] & (erm[1] | erm[0]);
      bit_l   = man_i[0];
      bit_r   = rs_i[1];
      bit_s   = rs_i[0];
      inc     = 1'b0;
      case (erm)
         RM_RNE:  inc = bit_r & (bit_s | bit_l);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign_i & (bit_r | bit_s);
         RM_RUP:  inc = ~sign_i & (bit_r | bit_s);
         RM_RMM:  inc = bit_r;
         default: inc = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_exp     <= '0;
         s1_man     <= '0;
         s1_inc     <= 1'b0;
         s1_erm     <= '0;
         s1_nx      <= 1'b0;
         s1_illegal <= 1'b0;
      end else begin
         if (flush_i) begin
            s1_valid <= 1'b0;
         end else if (advance) begin
            s1_valid <= in_valid_i;
         end
         if (advance && in_valid_i) begin
            s1_sign    <= sign_i;
            s1_exp     <= exp_i;
            s1_man     <= man_i;
            s1_inc     <= inc;
            s1_erm     <= erm;
            s1_nx      <= bit_r | bit_s;
            s1_illegal <= illegal;
         end
      end
   end

   always_comb begin
      sum = {1'b0, s1_man} + {{(MAN_W+1){1'b0}}, s1_inc};
      if (sum[MAN_W+1]) begin
         exp_f  = s1_exp + EXP_ONE;
         frac_f = '0;
      end else begin
         frac_f = sum[MAN_W-1:0];
         exp_f  = ((s1_exp == '0) && sum[MAN_W]) ? EXP_ONE : s1_exp;
      end
      // checking the pre-increment exponent too keeps a saturated input from wrapping to zero
      of        = (s1_exp >= EXP_OVF) || (exp_f >= EXP_OVF);
      of_to_inf = (s1_erm == RM_RNE) || (s1_erm == RM_RMM) ||
                  ((s1_erm == RM_RUP) && !s1_sign) || ((s1_erm == RM_RDN) && s1_sign);
      nx        = s1_nx | of;
      uf        = (exp_f == '0) && nx && !of;
      if (s1_illegal) begin
         res_n   = '0;
         flags_n = '0;
      end else if (of) begin
         res_n   = of_to_inf ? {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {s1_sign, EXP_MAXF, {MAN_W{1'b1}}};
         flags_n = {1'b1, 1'b0, 1'b1};
      end else begin
         res_n   = {s1_sign, exp_f[EXP_W-1:0], frac_f};
         flags_n = {1'b0, uf, nx};
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s2_valid     <= 1'b0;
         result_o     <= '0;
         fflags_o     <= '0;
         illegal_rm_o <= 1'b0;
      end else begin
         if (flush_i) begin
            s2_valid <= 1'b0;
         end else if (advance) begin
            s2_valid <= s1_valid;
         end
         if (advance && s1_valid) begin
            result_o     <= res_n;
            fflags_o     <= flags_n;
            illegal_rm_o <= s1_illegal;
         end
      end
   end

endmodule
